// File: rtl/loss_sequencer.sv
// Training-loop controller and loss stage for the fc binary layer: sequences the
// forward/backward phase strobes, captures the per-bit error vector and tracks convergence.
module loss_sequencer #(
  parameter int N            = 9,
  parameter int PHASE_CYCLES = 3,
  parameter int CONV_EPOCHS  = 2,
  parameter int EPOCH_W      = 16,
  parameter int MAX_EPOCHS   = 10000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [N-1:0]           target_in,
  input  logic [N-1:0]           fout_in,
  output logic                   fd_prop,
  output logic                   bk_prop,
  output logic [N-1:0]           bin,
  output logic [$clog2(N+1)-1:0] err_count,
  output logic [EPOCH_W-1:0]     epoch_count,
  output logic                   busy,
  output logic                   done,
  output logic                   converged
);

  localparam int CNT_W    = $clog2(N + 1);
  localparam int PH_W     = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int STREAK_W = $clog2(CONV_EPOCHS + 1);

  localparam logic [PH_W-1:0]     PH_LAST    = PH_W'(PHASE_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CONV_EPOCHS);
  localparam logic [EPOCH_W-1:0]  EPOCH_MAX  = EPOCH_W'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_BWD,
    S_CHECK,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [N-1:0]        bin_q, bin_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic                conv_q, conv_d;
  logic                fd_q, fd_d;
  logic                bk_q, bk_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N-1:0]        diff;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign diff = target_in ^ fout_in;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    phase_d  = phase_q;
    streak_d = streak_q;
    bin_d    = bin_q;
    err_d    = err_q;
    epoch_d  = epoch_q;
    conv_d   = conv_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_d  = S_FWD;
          phase_d  = '0;
          epoch_d  = '0;
          streak_d = '0;
          conv_d   = 1'b0;
        end
      end
      S_FWD: begin
        if (phase_q == PH_LAST) begin
          // The error vector is sampled only on the edge that leaves the forward phase.
          phase_d = '0;
          bin_d   = diff;
          err_d   = popcount(diff);
          state_d = S_BWD;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_BWD: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = S_CHECK;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_CHECK: begin
        epoch_d  = epoch_q + 1'b1;
        streak_d = (err_q == '0) ? streak_q + 1'b1 : '0;
        // Convergence is tested first so it wins over a simultaneous epoch limit.
        if (streak_d == STREAK_MAX) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (epoch_d == EPOCH_MAX) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else begin
          state_d = S_FWD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they are registered with it.
    fd_d   = (state_d == S_FWD);
    bk_d   = (state_d == S_BWD);
    busy_d = (state_d == S_FWD) || (state_d == S_BWD) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      streak_q <= '0;
      bin_q    <= '0;
      err_q    <= '0;
      epoch_q  <= '0;
      conv_q   <= 1'b0;
      fd_q     <= 1'b0;
      bk_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      phase_q  <= phase_d;
      streak_q <= streak_d;
      bin_q    <= bin_d;
      err_q    <= err_d;
      epoch_q  <= epoch_d;
      conv_q   <= conv_d;
      fd_q     <= fd_d;
      bk_q     <= bk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fd_prop     = fd_q;
  assign bk_prop     = bk_q;
  assign bin         = bin_q;
  assign err_count   = err_q;
  assign epoch_count = epoch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;

endmodule

// File: tb/tb_loss_sequencer.sv
// Bench for loss_sequencer: two instances (default limit and a 4-epoch limit) share stimulus
// and are compared every cycle against an epoch-offset reference model.
module tb_loss_sequencer;

  localparam int N     = 9;
  localparam int P     = 3;
  localparam int CONV  = 2;
  localparam int EW    = 16;
  localparam int MAX_A = 10000;
  localparam int MAX_B = 4;
  localparam int CW    = $clog2(N + 1);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [N-1:0]  target_in = '0;
  logic [N-1:0]  fout_in = '0;

  logic          fd_a, bk_a, busy_a, done_a, conv_a;
  logic [N-1:0]  bin_a;
  logic [CW-1:0] err_a;
  logic [EW-1:0] ep_a;
  logic          fd_b, bk_b, busy_b, done_b, conv_b;
  logic [N-1:0]  bin_b;
  logic [CW-1:0] err_b;
  logic [EW-1:0] ep_b;

  loss_sequencer #(.N(N), .PHASE_CYCLES(P), .CONV_EPOCHS(CONV), .EPOCH_W(EW), .MAX_EPOCHS(MAX_A)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .target_in(target_in), .fout_in(fout_in),
    .fd_prop(fd_a), .bk_prop(bk_a), .bin(bin_a), .err_count(err_a), .epoch_count(ep_a),
    .busy(busy_a), .done(done_a), .converged(conv_a));

  loss_sequencer #(.N(N), .PHASE_CYCLES(P), .CONV_EPOCHS(CONV), .EPOCH_W(EW), .MAX_EPOCHS(MAX_B)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .target_in(target_in), .fout_in(fout_in),
    .fd_prop(fd_b), .bk_prop(bk_b), .bin(bin_b), .err_count(err_b), .epoch_count(ep_b),
    .busy(busy_b), .done(done_b), .converged(conv_b));

  always #5 clk_in = ~clk_in;

  // Model: 'off' is the position (0..2P) of the current cycle inside its epoch.
  typedef struct {
    bit           running;
    int           off;
    int           epoch;
    int           streak;
    bit [N-1:0]   bin;
    int           err;
    bit           done;
    bit           conv;
    int           max_ep;
  } model_t;

  model_t       ma, mb;
  logic [N-1:0] mask_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic model_t model_reset(input int max_ep);
    model_t m;
    m.running = 0; m.off = 0; m.epoch = 0; m.streak = 0;
    m.bin = '0; m.err = 0; m.done = 0; m.conv = 0; m.max_ep = max_ep;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input bit start, input bit [N-1:0] diff);
    if (!m.running) begin
      if (start) begin
        m.running = 1; m.off = 0; m.epoch = 0; m.streak = 0; m.done = 0; m.conv = 0;
      end
    end else if (m.off == P - 1) begin
      m.bin = diff;
      m.err = $countones(diff);
      m.off++;
    end else if (m.off == 2 * P) begin
      m.epoch++;
      m.streak = (m.err == 0) ? m.streak + 1 : 0;
      if (m.streak == CONV) begin
        m.running = 0; m.done = 1; m.conv = 1;
      end else if (m.epoch == m.max_ep) begin
        m.running = 0; m.done = 1; m.conv = 0;
      end else begin
        m.off = 0;
      end
    end else begin
      m.off++;
    end
    return m;
  endfunction

  task automatic check_dut(input string p, input model_t m, input logic fd, input logic bk,
                           input logic [N-1:0] b, input logic [CW-1:0] e, input logic [EW-1:0] ep,
                           input logic bs, input logic dn, input logic cv);
    check({p, ".fd_prop"}, 32'(fd), 32'(m.running && m.off < P));
    check({p, ".bk_prop"}, 32'(bk), 32'(m.running && m.off >= P && m.off < 2 * P));
    check({p, ".bin"}, 32'(b), 32'(m.bin));
    check({p, ".err_count"}, 32'(e), 32'(m.err));
    check({p, ".epoch_count"}, 32'(ep), 32'(m.epoch));
    check({p, ".busy"}, 32'(bs), 32'(m.running));
    check({p, ".done"}, 32'(dn), 32'(m.done));
    check({p, ".converged"}, 32'(cv), 32'(m.conv));
    check({p, ".excl"}, 32'(fd & bk), 32'd0);
  endtask

  task automatic compare_all();
    check_dut("a", ma, fd_a, bk_a, bin_a, err_a, ep_a, busy_a, done_a, conv_a);
    check_dut("b", mb, fd_b, bk_b, bin_b, err_b, ep_b, busy_b, done_b, conv_b);
  endtask

  task automatic cycle();
    @(posedge clk_in);
    ma = model_step(ma, start_in, target_in ^ fout_in);
    mb = model_step(mb, start_in, target_in ^ fout_in);
    cyc++;
    #1;
    compare_all();
  endtask

  // Off the capture cycle fout is pure noise; on it, the error pattern for this epoch is applied.
  task automatic drive_fout();
    logic [N-1:0] m;
    if (ma.running && ma.off == P - 1) begin
      if (ma.epoch < mask_q.size()) m = mask_q[ma.epoch];
      else m = ($urandom_range(0, 1) == 1) ? '0 : N'($urandom);
      fout_in = target_in ^ m;
    end else begin
      fout_in = N'($urandom);
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    drive_fout();
    cycle();
    start_cyc = cyc;
    start_in = 1'b0;
  endtask

  task automatic run_until_done(input bit use_b, input int budget, output int latency);
    latency = -1;
    for (int i = 0; i < budget; i++) begin
      drive_fout();
      cycle();
      if (use_b ? done_b : done_a) begin
        latency = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    #2 rst_in = 1'b0;
    #1;
    ma = model_reset(MAX_A);
    mb = model_reset(MAX_B);
    compare_all();
    start_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    ma = model_reset(MAX_A);
    mb = model_reset(MAX_B);

    // Reset values with random inputs toggling underneath.
    #1 rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_in  = 1'($urandom);
      target_in = N'($urandom);
      fout_in   = N'($urandom);
      @(posedge clk_in);
      #1;
      compare_all();
    end
    start_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fout_in = N'($urandom);
      cycle();
    end

    // Convergence with defaults: two clean epochs, done 14 cycles after start.
    target_in = 9'b101111001;
    mask_q = {};
    for (int i = 0; i < 4; i++) mask_q.push_back('0);
    pulse_start();
    run_until_done(1'b0, 60, lat);
    check("t2.done_latency", 32'(lat), 32'd14);
    check("t2.epoch", 32'(ep_a), 32'd2);
    check("t2.converged", 32'(conv_a), 32'd1);
    check("t2.bin", 32'(bin_a), 32'd0);

    // Timeout from DONE: every bit wrong, 4-epoch instance stops unconverged after 28 cycles.
    target_in = N'($urandom);
    mask_q = {};
    for (int i = 0; i < 8; i++) mask_q.push_back('1);
    pulse_start();
    run_until_done(1'b1, 60, lat);
    check("t3.done_latency", 32'(lat), 32'd28);
    check("t3.bin", 32'(bin_b), 32'h1FF);
    check("t3.err_count", 32'(err_b), 32'd9);
    check("t3.epoch", 32'(ep_b), 32'd4);
    check("t3.converged", 32'(conv_b), 32'd0);
    apply_reset();

    // Streak reset: errors 0,3,0,0 converge at epoch 4; on the 4-epoch instance this
    // coincides with the limit and convergence must win.
    target_in = N'($urandom);
    mask_q = {9'b000000000, 9'b000010101, 9'b000000000, 9'b000000000};
    pulse_start();
    run_until_done(1'b0, 80, lat);
    check("t4.done_latency", 32'(lat), 32'd28);
    check("t4.epoch_a", 32'(ep_a), 32'd4);
    check("t4.converged_a", 32'(conv_a), 32'd1);
    check("t4.epoch_b", 32'(ep_b), 32'd4);
    check("t4.converged_b", 32'(conv_b), 32'd1);

    // Randomised segments: random error patterns, noisy fout, stray start requests.
    mask_q = {};
    for (int s = 0; s < 3; s++) begin
      apply_reset();
      target_in = N'($urandom);
      for (int i = 0; i < 300; i++) begin
        start_in = ($urandom_range(0, 7) == 0);
        drive_fout();
        cycle();
      end
      start_in = 1'b0;
    end

    // Reset in the second BWD cycle, then restart from epoch 0.
    apply_reset();
    target_in = N'($urandom);
    pulse_start();
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      drive_fout();
      cycle();
      if (ma.running && ma.off == P + 1) begin
        lat = i;
        break;
      end
    end
    check("t6.reached_bwd", 32'(lat >= 0), 32'd1);
    apply_reset();
    pulse_start();
    for (int i = 0; i < 2 * (2 * P + 1); i++) begin
      drive_fout();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
